// File: rtl/pipe_alu.sv
// Pipelined ALU with a one-deep registered output stage and valid/ready handshakes.
// Define ALU_MUL_EN to build cntrl 111 as an iterative shift-add multiply; otherwise 111 yields zero.
module pipe_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // sender holds its payload until then and ready never waits on the same-side valid.

    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    logic             out_free, accept;
    logic             wr_en;
    logic [WIDTH-1:0] wr_res;
    logic             wr_v, wr_c;

    logic [WIDTH-1:0] alu_res;
    logic             alu_v, alu_c;
    logic             sub_w;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_w;

    always_comb begin
        sub_w   = (cntrl == 3'b011);
        b_op    = sub_w ? ~B : B;
        sum_w   = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_w};
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (cntrl)
            3'b000: alu_res = B;
            3'b001: alu_res = A;
            3'b010, 3'b011: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
            end
            3'b100: alu_res = A & B;
            3'b101: alu_res = A | B;
            3'b110: alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_BUSY} state_t;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_done;

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign mul_done  = (state_q == S_BUSY) && (cnt_q == CNT_W'(WIDTH));
    assign dbg_state = (state_q == S_BUSY);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && cntrl == 3'b111) begin
                    state_d  = S_BUSY;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    cnt_d    = '0;
                end
            end
            S_BUSY: begin
                if (!mul_done) begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (out_free) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // A finished product waits in the accumulator until the output slot frees up.
    always_comb begin
        wr_en  = 1'b0;
        wr_res = alu_res;
        wr_v   = alu_v;
        wr_c   = alu_c;
        if (mul_done && out_free) begin
            wr_en  = 1'b1;
            wr_res = acc_q[WIDTH-1:0];
            wr_v   = |acc_q[2*WIDTH-1:WIDTH];
            wr_c   = 1'b0;
        end else if (accept && cntrl != 3'b111) begin
            wr_en = 1'b1;
        end
    end
`else
    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = out_free;
    assign accept    = in_valid && in_ready;
    assign dbg_state = 1'b0;

    always_comb begin
        wr_en  = accept;
        wr_res = alu_res;
        wr_v   = alu_v;
        wr_c   = alu_c;
    end
`endif

    always_comb begin
        result_d    = result_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        if (wr_en) begin
            result_d    = wr_res;
            neg_d       = wr_res[WIDTH-1];
            zero_d      = (wr_res == '0);
            ovf_d       = wr_v;
            cout_d      = wr_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;
    assign out_valid = out_valid_q;

endmodule
